// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver: synchronizes/filters the bus, deframes 11-bit frames and
// assembles 3-byte packets. Define PS2_INIT_EN to send the 0xF4 enable command after reset.
module ps2_mouse_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned INHIBIT_CYCLES = 12000
) (
    input  logic       iBusClk,
    input  logic       iRstN,
    inout  wire        ps2clk,
    inout  wire        ps2data,
    output logic [8:0] oXm,
    output logic [8:0] oYm,
    output logic [2:0] oButton,
    output logic       oDone,
    output logic       oFrameErr
);

    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam int unsigned FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          clk_diff, filt_flip, sample_evt, ps2d;

    rx_state_t     rx_state, rx_next;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic          byte_ok, byte_bad;

    logic [1:0]    pkt_idx;
    logic [7:0]    b0, b1;
    logic [TW-1:0] tmr;
    logic          busy, tmo, err_evt;

    logic          rx_en, pkt_en, host_busy, host_err;

    assign ps2d       = dat_sync[1];
    assign clk_diff   = clk_sync[1] != filt_clk;
    assign filt_flip  = clk_diff && (filt_cnt == FW'(FILTER_LEN - 1));
    assign sample_evt = filt_flip && filt_clk;

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            clk_sync <= '1;
            dat_sync <= '1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2clk};
            dat_sync <= {dat_sync[0], ps2data};
            if (!clk_diff) begin
                filt_cnt <= '0;
            end else if (filt_flip) begin
                filt_cnt <= '0;
                filt_clk <= clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Timer runs only while a frame or packet is outstanding; any falling edge restarts it.
    assign busy = (rx_state != RX_IDLE) || (pkt_idx != 2'd0) || host_busy;
    assign tmo  = busy && !sample_evt && (tmr == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN)                      tmr <= '0;
        else if (sample_evt || !busy || tmo) tmr <= '0;
        else                             tmr <= tmr + TW'(1);
    end

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next  = rx_state;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        if (tmo) begin
            rx_next = RX_IDLE;
        end else if (sample_evt && rx_en) begin
            case (rx_state)
                RX_IDLE:   if (!ps2d) rx_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) rx_next = RX_PARITY;
                RX_PARITY: rx_next = RX_STOP;
                RX_STOP: begin
                    if (ps2d && (^{shreg, par_bit})) byte_ok  = 1'b1;
                    else                             byte_bad = 1'b1;
                    rx_next = RX_IDLE;
                end
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else if (sample_evt && rx_en) begin
            case (rx_state)
                RX_IDLE:   bit_cnt <= '0;
                RX_DATA: begin
                    shreg   <= {ps2d, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                RX_PARITY: par_bit <= ps2d;
                default:   ;
            endcase
        end
    end

    function automatic logic [8:0] sat(input logic ovf, input logic sign, input logic [7:0] mag);
        if (ovf) return sign ? 9'h101 : 9'h0FF;
        return {sign, mag};
    endfunction

    assign err_evt = tmo || byte_bad || host_err;

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            pkt_idx   <= '0;
            b0        <= '0;
            b1        <= '0;
            oXm       <= '0;
            oYm       <= '0;
            oButton   <= '0;
            oDone     <= 1'b0;
            oFrameErr <= 1'b0;
        end else begin
            oDone     <= 1'b0;
            oFrameErr <= 1'b0;
            if (err_evt) begin
                pkt_idx   <= '0;
                oFrameErr <= 1'b1;
            end else if (byte_ok && pkt_en) begin
                case (pkt_idx)
                    2'd0: begin
                        if (shreg[3]) begin
                            b0      <= shreg;
                            pkt_idx <= 2'd1;
                        end else begin
                            oFrameErr <= 1'b1;
                        end
                    end
                    2'd1: begin
                        b1      <= shreg;
                        pkt_idx <= 2'd2;
                    end
                    default: begin
                        oXm     <= sat(b0[6], b0[4], b1);
                        oYm     <= sat(b0[7], b0[5], shreg);
                        oButton <= b0[2:0];
                        oDone   <= 1'b1;
                        pkt_idx <= 2'd0;
                    end
                endcase
            end
        end
    end

`ifdef PS2_INIT_EN
    typedef enum logic [2:0] {H_INHIBIT, H_SEND, H_ACK, H_RESP, H_DONE} host_state_t;
    localparam logic [8:0] TX_WORD = {1'b0, 8'hF4};

    host_state_t   host_state, host_next;
    logic [TW-1:0] inh_cnt;
    logic [3:0]    tx_idx;
    logic          clk_low, dat_low, inh_done;

    assign inh_done  = clk_low && (inh_cnt == TW'(INHIBIT_CYCLES - 1));
    assign rx_en     = (host_state == H_RESP) || (host_state == H_DONE);
    assign pkt_en    = host_state == H_DONE;
    assign host_busy = (host_state == H_SEND) || (host_state == H_ACK) || (host_state == H_RESP);
    assign ps2clk    = clk_low ? 1'b0 : 1'bz;
    assign ps2data   = dat_low ? 1'b0 : 1'bz;

    always_comb begin
        host_next = host_state;
        host_err  = 1'b0;
        case (host_state)
            H_INHIBIT: if (inh_done) host_next = H_SEND;
            H_SEND: begin
                if (tmo)                                host_next = H_INHIBIT;
                else if (sample_evt && tx_idx == 4'd9) host_next = H_ACK;
            end
            H_ACK: begin
                if (tmo) begin
                    host_next = H_INHIBIT;
                end else if (sample_evt) begin
                    host_next = ps2d ? H_INHIBIT : H_RESP;
                    host_err  = ps2d;
                end
            end
            H_RESP: begin
                if (tmo || byte_bad) begin
                    host_next = H_INHIBIT;
                end else if (byte_ok) begin
                    host_next = (shreg == 8'hFA) ? H_DONE : H_INHIBIT;
                    host_err  = shreg != 8'hFA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            host_state <= H_INHIBIT;
            inh_cnt    <= '0;
            tx_idx     <= '0;
            clk_low    <= 1'b0;
            dat_low    <= 1'b0;
        end else begin
            host_state <= host_next;
            case (host_state)
                H_INHIBIT: begin
                    clk_low <= 1'b1;
                    dat_low <= 1'b0;
                    tx_idx  <= '0;
                    if (inh_done) begin
                        inh_cnt <= '0;
                        clk_low <= 1'b0;
                        dat_low <= 1'b1;
                    end else if (clk_low) begin
                        inh_cnt <= inh_cnt + TW'(1);
                    end
                end
                H_SEND: begin
                    if (sample_evt) begin
                        dat_low <= (tx_idx == 4'd9) ? 1'b0 : ~TX_WORD[tx_idx];
                        tx_idx  <= tx_idx + 4'd1;
                    end
                end
                default: ;
            endcase
            // Any abort releases data and re-enters the inhibit phase immediately.
            if (host_next == H_INHIBIT && host_state != H_INHIBIT) begin
                dat_low <= 1'b0;
                clk_low <= 1'b1;
            end
        end
    end
`else
    assign rx_en     = 1'b1;
    assign pkt_en    = 1'b1;
    assign host_busy = 1'b0;
    assign host_err  = 1'b0;
    assign ps2clk    = 1'bz;
    assign ps2data   = 1'bz;
`endif

endmodule
